// File: rtl/debug_pkg.sv
// debug_pkg: shared types for the probe capture scheduler. Rev 1.0
`default_nettype none

package debug_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } cap_state_e;

   localparam int DBG_WORD_W = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from last+1 upward. Rev 1.0
`default_nettype none

module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   int            pos;
   logic [IW-1:0] pos_w;
   logic          found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      pos_w = '0;
      // k runs 1..N so the previous winner is visited last
      for (int k = 1; k <= N; k++) begin
         pos   = (int'(last) + k) % N;
         pos_w = IW'(pos);
         if (!found && req[pos_w]) begin
            found      = 1'b1;
            gnt[pos_w] = 1'b1;
            idx        = pos_w;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/probe_capture_sched.sv
// probe_capture_sched: round-robin sharing of the logic-analyser probe port
// between NUM_SRC debug taps, with per-run sample budget. Rev 1.0
`default_nettype none

module probe_capture_sched
   import debug_pkg::*;
#(
   parameter int NUM_SRC  = 4,
   parameter int HOLD_CYC = 4,
   parameter int CNT_W    = 16,
   parameter int IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          arm,
   input  logic [CNT_W-1:0]              cap_limit,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*DBG_WORD_W-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic                          probe0,
   output logic [7:0]                    probe1,
   output logic [7:0]                    probe2,
   output logic [IW-1:0]                 grant_id,
   output logic                          busy,
   output logic                          done,
   output logic [CNT_W-1:0]              sample_cnt
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_ARB  = ARB;
   localparam logic [1:0] ST_HOLD = HOLD;
   localparam logic [1:0] ST_DONE = DONE;

   localparam int            HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYC - 1);

   logic [1:0]            state_q, state_d;
   logic [IW-1:0]         last_q, last_d;
   logic [CNT_W-1:0]      limit_q, limit_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic                  p0_q, p0_d;
   logic [7:0]            p1_q, p1_d;
   logic [7:0]            p2_q, p2_d;
   logic [IW-1:0]         gid_q, gid_d;

   logic [NUM_SRC-1:0]    gnt;
   logic [IW-1:0]         gidx;
   logic [DBG_WORD_W-1:0] word;
   logic [CNT_W-1:0]      cnt_inc;

   rr_arbiter #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_arb (
      .req  (src_valid),
      .last (last_q),
      .gnt  (gnt),
      .idx  (gidx)
   );

   always_comb begin
      word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gidx == IW'(i)) word = src_data[i*DBG_WORD_W +: DBG_WORD_W];
      end
   end

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      limit_d   = limit_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      p0_d      = 1'b0;
      p1_d      = p1_q;
      p2_d      = p2_q;
      gid_d     = gid_q;
      src_ready = '0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               state_d = ST_ARB;
               limit_d = cap_limit;
               cnt_d   = '0;
            end
         end
         ST_ARB: begin
            if (|src_valid) begin
               src_ready = gnt;
               p0_d      = 1'b1;
               p1_d      = word[15:8];
               p2_d      = word[7:0];
               gid_d     = gidx;
               last_d    = gidx;
               hold_d    = HOLD_INIT;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q == '0) begin
               cnt_d   = cnt_inc;
               // a zero limit means the run never ends on its own
               state_d = (limit_q != '0 && cnt_inc == limit_q) ? ST_DONE : ST_ARB;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= IW'(NUM_SRC - 1);
         limit_q <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         p0_q    <= 1'b0;
         p1_q    <= '0;
         p2_q    <= '0;
         gid_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         limit_q <= limit_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         gid_q   <= gid_d;
      end
   end

   assign probe0     = p0_q;
   assign probe1     = p1_q;
   assign probe2     = p2_q;
   assign grant_id   = gid_q;
   assign sample_cnt = cnt_q;
   assign busy       = (state_q == ST_ARB) || (state_q == ST_HOLD);
   assign done       = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_probe_capture_sched.sv
// tb_probe_capture_sched: directed self-checking bench for probe_capture_sched. Rev 1.0
`default_nettype none

module tb_probe_capture_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm;
   logic [15:0] cap_limit;
   logic [3:0]  src_valid;
   logic [63:0] src_data;
   logic [3:0]  src_ready;
   logic        probe0;
   logic [7:0]  probe1;
   logic [7:0]  probe2;
   logic [1:0]  grant_id;
   logic        busy;
   logic        done;
   logic [15:0] sample_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int g_gnt[$];
   int g_word[$];

   probe_capture_sched #(
      .NUM_SRC  (4),
      .HOLD_CYC (4),
      .CNT_W    (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .cap_limit  (cap_limit),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ready  (src_ready),
      .probe0     (probe0),
      .probe1     (probe1),
      .probe2     (probe2),
      .grant_id   (grant_id),
      .busy       (busy),
      .done       (done),
      .sample_cnt (sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic arm_run(input logic [15:0] lim);
      @(negedge clk);
      cap_limit = lim;
      arm       = 1'b1;
      @(negedge clk);
      arm       = 1'b0;
   endtask

   // steps until done, logging every strobed sample and policing src_ready pulses
   task automatic run_until_done(input int max_cyc);
      logic [3:0] prev;
      prev = '0;
      g_gnt.delete();
      g_word.delete();
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (src_ready != '0) begin
            check("rdy_onehot", 32'($onehot(src_ready)), 1);
            check("rdy_one_cycle", 32'(prev), 0);
         end
         prev = src_ready;
         if (probe0) begin
            g_gnt.push_back(int'(grant_id));
            g_word.push_back(int'({probe1, probe2}));
         end
         if (done) break;
      end
      check("run_done", 32'(done), 1);
   endtask

   task automatic wait_p0(input int max_cyc, input bit need_nz);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (probe0 && (!need_nz || grant_id != 2'd0)) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_probe0", 32'(seen), 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      arm       = 1'b0;
      cap_limit = '0;
      src_valid = 4'b1111;
      src_data  = {16'h3300, 16'h2200, 16'h1100, 16'h0000};

      // reset and idle
      repeat (5) @(negedge clk);
      check("rst_probe0", 32'(probe0), 0);
      check("rst_probe1", 32'(probe1), 0);
      check("rst_probe2", 32'(probe2), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_cnt", 32'(sample_cnt), 0);
      check("rst_grant", 32'(grant_id), 0);
      check("rst_ready", 32'(src_ready), 0);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("idle_ready", 32'(src_ready), 0);
         check("idle_busy", 32'(busy), 0);
      end

      // round robin across all four sources
      arm_run(16'd8);
      run_until_done(100);
      check("rr_count", 32'(g_gnt.size()), 8);
      for (int i = 0; i < g_gnt.size() && i < 8; i++) begin
         check("rr_grant", 32'(g_gnt[i]), 32'(i % 4));
         check("rr_word", 32'(g_word[i]), 32'(16'h1100 * (i % 4)));
      end
      check("rr_cnt", 32'(sample_cnt), 8);

      // single source, exact strobe timing
      src_valid = 4'b0001;
      src_data  = {16'h3300, 16'h2200, 16'h1100, 16'hA55A};
      @(negedge clk);
      cap_limit = 16'd3;
      arm       = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         arm = 1'b0;
         check("ss_probe0", 32'(probe0), (k == 2 || k == 7 || k == 12) ? 1 : 0);
         if (k == 1) check("ss_ready", 32'(src_ready), 32'h1);
         if (k == 2 || k == 5) begin
            check("ss_probe1", 32'(probe1), 32'hA5);
            check("ss_probe2", 32'(probe2), 32'h5A);
            check("ss_grant", 32'(grant_id), 0);
         end
         if (k == 15) check("ss_busy", 32'(busy), 1);
      end
      check("ss_done", 32'(done), 1);
      check("ss_cnt", 32'(sample_cnt), 3);

      // sparse requests: ARB idles with no strobe until a source appears
      src_valid = 4'b0000;
      src_data  = {16'h3300, 16'h2200, 16'h1100, 16'h0000};
      arm_run(16'd2);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("sp_wait_busy", 32'(busy), 1);
         check("sp_wait_p0", 32'(probe0), 0);
         check("sp_wait_rdy", 32'(src_ready), 0);
      end
      src_valid = 4'b0100;
      wait_p0(10, 1'b0);
      check("sp_grant2", 32'(grant_id), 2);
      check("sp_word2", 32'(probe1), 32'h22);
      src_valid = 4'b0010;
      run_until_done(30);
      check("sp_count", 32'(g_gnt.size()), 1);
      if (g_gnt.size() > 0) check("sp_grant1", 32'(g_gnt[0]), 1);
      check("sp_cnt", 32'(sample_cnt), 2);

      // arm during HOLD is ignored
      src_valid = 4'b0001;
      arm_run(16'd2);
      wait_p0(10, 1'b0);
      cap_limit = 16'd0;
      arm       = 1'b1;
      @(negedge clk);
      arm       = 1'b0;
      run_until_done(40);
      check("ai_cnt", 32'(sample_cnt), 2);

      // restart from DONE with unlimited budget
      src_valid = 4'b1111;
      arm_run(16'd0);
      repeat (560) @(negedge clk);
      check("ul_over100", 32'(sample_cnt > 16'd100), 1);
      check("ul_done", 32'(done), 0);
      check("ul_busy", 32'(busy), 1);

      // asynchronous reset on the second HOLD cycle
      wait_p0(20, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("ar_probe0", 32'(probe0), 0);
      check("ar_probe1", 32'(probe1), 0);
      check("ar_probe2", 32'(probe2), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_grant", 32'(grant_id), 0);
      check("ar_cnt", 32'(sample_cnt), 0);
      check("ar_ready", 32'(src_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      arm_run(16'd1);
      run_until_done(20);
      check("ar_count", 32'(g_gnt.size()), 1);
      if (g_gnt.size() > 0) check("ar_first_grant", 32'(g_gnt[0]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
